// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: issues imem requests, holds the fetched word
// for decode and turns the branch-control decisions into the next fetch address.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] INT_VEC   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pc_sel,
    input  logic [1:0]  branch_sel,
    input  logic        jmp_based_on_reg,
    input  logic [31:0] br_offset,
    input  logic [25:0] jmp_index,
    input  logic [31:0] reg_target,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_RST   = 2'b00,
        S_FETCH = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] epc_q, epc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_plus4_w;
    logic [31:0] next_pc;

    assign pc_plus4_w = pc_q + 32'd4;

    // Target selection; the interrupt vector takes priority over any branch decision.
    always_comb begin
        next_pc = pc_plus4_w;
        case (pc_sel)
            2'b00: next_pc = RESET_VEC;
            2'b01: next_pc = INT_VEC;
            2'b10: next_pc = pc_plus4_w;
            default: begin
                case (branch_sel)
                    2'b00:   next_pc = pc_plus4_w + (br_offset << 2);
                    2'b01:   next_pc = {reg_target[31:2], 2'b00};
                    2'b10:   next_pc = {pc_plus4_w[31:28], jmp_index, 2'b00};
                    default: next_pc = pc_plus4_w;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        epc_d         = epc_q;
        misalign_d    = 1'b0;
        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    pc_d          = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    fetch_pc_d    = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                    if (pc_sel == 2'b01) begin
                        epc_d = pc_plus4_w;
                    end
                    misalign_d = (pc_sel == 2'b11) && (branch_sel == 2'b01) &&
                                 (reg_target[1:0] != 2'b00);
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RST;
            fetch_pc_q    <= RESET_VEC;
            pc_q          <= RESET_VEC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            epc_q         <= 32'd0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            epc_q         <= epc_d;
            misalign_q    <= misalign_d;
        end
    end

    // Decode must flag register jumps consistently; branch_sel decides if it does not.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == S_HOLD && advance && pc_sel == 2'b11) |->
        (jmp_based_on_reg == (branch_sel == 2'b01)));

    assign imem_req     = (state_q == S_FETCH);
    assign imem_addr    = fetch_pc_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_w;
    assign epc          = epc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a hand-driven imem port and decode decisions,
// expected addresses computed by hand for each scenario.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pc_sel = 2'b10;
    logic [1:0]  branch_sel = 2'b00;
    logic        jmp_based_on_reg = 1'b0;
    logic [31:0] br_offset = 32'd0;
    logic [25:0] jmp_index = 26'd0;
    logic [31:0] reg_target = 32'd0;
    logic        advance = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        misalign_err;

    int tests_run = 0;
    int tests_failed = 0;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_sel(pc_sel), .branch_sel(branch_sel),
        .jmp_based_on_reg(jmp_based_on_reg), .br_offset(br_offset),
        .jmp_index(jmp_index), .reg_target(reg_target), .advance(advance),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for a request and acks it; a timeout returns a sentinel address.
    task automatic serve_fetch(input logic [31:0] data, output logic [31:0] addr);
        int n = 0;
        addr = 32'hDEAD_BEEF;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req) begin
            addr       = imem_addr;
            imem_rdata = data;
            imem_ack   = 1'b1;
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'd0;
        end
        $display("[TB] fetch addr=%08h data=%08h", addr, data);
    endtask

    task automatic do_advance(input logic [1:0] ps, input logic [1:0] bs,
                              input logic [31:0] off, input logic [25:0] ji,
                              input logic [31:0] rt);
        pc_sel           = ps;
        branch_sel       = bs;
        jmp_based_on_reg = (bs == 2'b01);
        br_offset        = off;
        jmp_index        = ji;
        reg_target       = rt;
        advance          = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        $display("[TB] advance pc_sel=%b branch_sel=%b -> imem_addr=%08h", ps, bs, imem_addr);
    endtask

    task automatic test_reset();
        logic [31:0] a;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({instr_valid, imem_req, misalign_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got valid/req/mis=%b%b%b want 000", instr_valid, imem_req, misalign_err);
        end
        tests_run++;
        if ({pc, epc, instr} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_regs got pc=%08h epc=%08h instr=%08h want all 0", pc, epc, instr);
        end
        reset = 1'b0;
        serve_fetch(32'h1111_0001, a);
        tests_run++;
        if (a !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_first_addr got %08h want 00000000", a);
        end
        tests_run++;
        if ({instr_valid, pc, instr} !== {1'b1, 32'h0, 32'h1111_0001}) begin
            tests_failed++;
            $display("FAIL reset_first_instr got v=%b pc=%08h instr=%08h want 1 00000000 11110001", instr_valid, pc, instr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        do_advance(2'b11, 2'b01, 32'd0, 26'd0, 32'h0000_0100);
        serve_fetch(32'h2222_0100, a);
        tests_run++;
        if (a !== 32'h100) begin
            tests_failed++;
            $display("FAIL seq_regjump got %08h want 00000100", a);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({instr_valid, imem_req, instr, pc_plus4} !== {1'b1, 1'b0, 32'h2222_0100, 32'h104}) begin
            tests_failed++;
            $display("FAIL seq_hold got v=%b req=%b instr=%08h pc4=%08h want 1 0 22220100 00000104", instr_valid, imem_req, instr, pc_plus4);
        end
        do_advance(2'b10, 2'b00, 32'd0, 26'd0, 32'd0);
        tests_run++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h104}) begin
            tests_failed++;
            $display("FAIL seq_pc4 got v=%b req=%b addr=%08h want 0 1 00000104", instr_valid, imem_req, imem_addr);
        end
        serve_fetch(32'h2222_0104, a);
    endtask

    task automatic test_branch();
        logic [31:0] a;
        do_advance(2'b11, 2'b01, 32'd0, 26'd0, 32'h0000_0100);
        serve_fetch(32'h3333_0100, a);
        do_advance(2'b11, 2'b00, 32'hFFFF_FFFE, 26'd0, 32'd0);
        tests_run++;
        if (imem_addr !== 32'h0000_00FC) begin
            tests_failed++;
            $display("FAIL branch_back got %08h want 000000fc", imem_addr);
        end
        serve_fetch(32'h3333_00FC, a);
        do_advance(2'b11, 2'b01, 32'd0, 26'd0, 32'hFFFF_FFF0);
        serve_fetch(32'h3333_FFF0, a);
        do_advance(2'b11, 2'b00, 32'h3FFF_FFFF, 26'd0, 32'd0);
        tests_run++;
        if (imem_addr !== 32'hFFFF_FFF0) begin
            tests_failed++;
            $display("FAIL branch_wrap got %08h want fffffff0", imem_addr);
        end
        serve_fetch(32'h3333_FFF1, a);
    endtask

    task automatic test_jump();
        logic [31:0] a;
        do_advance(2'b11, 2'b01, 32'd0, 26'd0, 32'h1000_0000);
        serve_fetch(32'h4444_0000, a);
        do_advance(2'b11, 2'b10, 32'd0, 26'h40, 32'd0);
        tests_run++;
        if ({imem_addr, misalign_err} !== {32'h1000_0100, 1'b0}) begin
            tests_failed++;
            $display("FAIL jump_imm got addr=%08h mis=%b want 10000100 0", imem_addr, misalign_err);
        end
        serve_fetch(32'h4444_0100, a);
        do_advance(2'b11, 2'b01, 32'd0, 26'd0, 32'h0000_0203);
        tests_run++;
        if ({imem_addr, misalign_err} !== {32'h200, 1'b1}) begin
            tests_failed++;
            $display("FAIL jump_reg_misalign got addr=%08h mis=%b want 00000200 1", imem_addr, misalign_err);
        end
        @(negedge clk);
        tests_run++;
        if (misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_pulse got %b want 0", misalign_err);
        end
        serve_fetch(32'h4444_0200, a);
    endtask

    task automatic test_interrupt();
        logic [31:0] a;
        do_advance(2'b01, 2'b00, 32'd5, 26'd0, 32'd0);
        tests_run++;
        if ({imem_addr, epc} !== {32'h80, 32'h204}) begin
            tests_failed++;
            $display("FAIL int_entry got addr=%08h epc=%08h want 00000080 00000204", imem_addr, epc);
        end
        serve_fetch(32'h5555_0080, a);
        do_advance(2'b10, 2'b00, 32'd0, 26'd0, 32'd0);
        tests_run++;
        if ({imem_addr, epc} !== {32'h84, 32'h204}) begin
            tests_failed++;
            $display("FAIL epc_hold got addr=%08h epc=%08h want 00000084 00000204", imem_addr, epc);
        end
        serve_fetch(32'h5555_0084, a);
        do_advance(2'b00, 2'b10, 32'd0, 26'h1234, 32'd0);
        tests_run++;
        if (imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_vec_sel got %08h want 00000000", imem_addr);
        end
        serve_fetch(32'h5555_0000, a);
    endtask

    task automatic test_reset_stall();
        logic [31:0] a;
        do_advance(2'b10, 2'b00, 32'd0, 26'd0, 32'd0);
        pc_sel           = 2'b11;
        branch_sel       = 2'b01;
        jmp_based_on_reg = 1'b1;
        reg_target       = 32'h300;
        advance          = 1'b1;
        repeat (5) @(negedge clk);
        advance = 1'b0;
        tests_run++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h4}) begin
            tests_failed++;
            $display("FAIL stall_hold got req=%b v=%b addr=%08h want 1 0 00000004", imem_req, instr_valid, imem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL stall_reset got req=%b v=%b want 0 0", imem_req, instr_valid);
        end
        reset = 1'b0;
        serve_fetch(32'h6666_0000, a);
        tests_run++;
        if ({a, pc, instr_valid} !== {32'h0, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_refetch got addr=%08h pc=%08h v=%b want 00000000 00000000 1", a, pc, instr_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_interrupt();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
